morse_key_timer: RTL and testbench

Single-key Morse front end for the decode path. Synchronises and debounces one raw push-button, times each press and each release gap, and emits one-cycle dot, dash, confirm and backspace pulses. These pulses feed the decoder controller's `dots`, `dashes`, `confirm` and `backspace` inputs, which replaces the three separate buttons with one telegraph key.

---
 rtl/morse_pkg.sv | 28 ++
 rtl/morse_key_timer_debounce.sv | 50 +++++
 rtl/morse_key_timer.sv | 135 +++++++++++++
 tb/tb_morse_key_timer.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared definitions for the single-key Morse front end: FSM state encoding,
// default 100 MHz cycle constants, reduced simulation constants and a small
// helper used to size the timing counter.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } morse_state_t;

  // Default cycle counts for a 100 MHz system clock
  localparam int DEF_DEBOUNCE_CYC = 2_000_000;
  localparam int DEF_DASH_CYC     = 30_000_000;
  localparam int DEF_BKSP_CYC     = 150_000_000;
  localparam int DEF_GAP_CYC      = 70_000_000;

  // Reduced cycle counts so simulations finish quickly
  localparam int SIM_DEBOUNCE_CYC = 4;
  localparam int SIM_DASH_CYC     = 20;
  localparam int SIM_BKSP_CYC     = 60;
  localparam int SIM_GAP_CYC      = 40;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/morse_key_timer_debounce.sv
// key_debounce: two-flop synchroniser followed by a stable-count debouncer.
// The debounced level only changes after the synchronised key has differed
// from it for DEBOUNCE_CYC consecutive cycles.
module key_debounce
  import morse_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic deb
);

  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYC - 1);

  logic          sync_1;
  logic          key_s;
  logic [DW-1:0] stable_cnt;

  // Bring the asynchronous key into the clock domain through two flops
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b0;
      key_s  <= 1'b0;
    end else begin
      sync_1 <= key;
      key_s  <= sync_1;
    end
  end

  // Count cycles of disagreement; adopt the new level once it has held long enough
  always_ff @(posedge clk) begin
    if (rst) begin
      deb        <= 1'b0;
      stable_cnt <= '0;
    end else if (key_s != deb) begin
      if (stable_cnt == LAST) begin
        deb        <= key_s;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + DW'(1);
      end
    end else begin
      stable_cnt <= '0;
    end
  end

endmodule

// File: rtl/morse_key_timer.sv
// morse_key_timer: one telegraph key in, dot/dash/backspace/confirm pulses out.
// Press length picks the symbol, a long enough release ends the letter.
// Optional feature macro: MORSE_DASH_LED_EN drives dash_ready as live
// feedback that the current press has reached dash length; without it
// dash_ready is tied low.
module morse_key_timer
  import morse_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int DASH_CYC     = DEF_DASH_CYC,
  parameter int BKSP_CYC     = DEF_BKSP_CYC,
  parameter int GAP_CYC      = DEF_GAP_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic dot,
  output logic dash,
  output logic backspace,
  output logic confirm,
  output logic busy,
  output logic dash_ready
);

  localparam int CW = $clog2(max_int(BKSP_CYC, GAP_CYC) + 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] DASH_TH  = CW'(DASH_CYC);
  localparam logic [CW-1:0] BKSP_TH  = CW'(BKSP_CYC);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);

  logic          deb;
  morse_state_t  state;
  morse_state_t  state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          dot_set;
  logic          dash_set;
  logic          bksp_set;
  logic          conf_set;

  key_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk(clk),
    .rst(rst),
    .key(key),
    .deb(deb)
  );

  // Next-state and pulse decisions; a key rise in GAP beats the gap timeout
  always_comb begin
    state_next = state;
    dot_set    = 1'b0;
    dash_set   = 1'b0;
    bksp_set   = 1'b0;
    conf_set   = 1'b0;
    case (state)
      IDLE: begin
        if (deb) state_next = PRESS;
      end
      PRESS: begin
        if (!deb) begin
          if (cnt < DASH_TH) begin
            dot_set    = 1'b1;
            state_next = GAP;
          end else if (cnt < BKSP_TH) begin
            dash_set   = 1'b1;
            state_next = GAP;
          end else begin
            bksp_set   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      GAP: begin
        if (deb) begin
          state_next = PRESS;
        end else if (cnt == GAP_LAST) begin
          conf_set   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Timing counter restarts on every state entry and sticks at its top value
  always_comb begin
    cnt_next = cnt;
    if (state_next != state) begin
      cnt_next = '0;
    end else if (cnt != CNT_MAX) begin
      cnt_next = cnt + CW'(1);
    end
  end

  // State, counter and registered one-cycle output pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dot       <= 1'b0;
      dash      <= 1'b0;
      backspace <= 1'b0;
      confirm   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      dot       <= dot_set;
      dash      <= dash_set;
      backspace <= bksp_set;
      confirm   <= conf_set;
    end
  end

  assign busy = (state != IDLE);

`ifdef MORSE_DASH_LED_EN
  logic dash_ready_q;

  // Track next-cycle state so the LED lines up exactly with PRESS and cnt
  always_ff @(posedge clk) begin
    if (rst) begin
      dash_ready_q <= 1'b0;
    end else begin
      dash_ready_q <= (state_next == PRESS) && (cnt_next >= DASH_TH);
    end
  end

  assign dash_ready = dash_ready_q;
`else
  assign dash_ready = 1'b0;
`endif

endmodule

// File: tb/tb_morse_key_timer.sv
// Self-checking bench for morse_key_timer using the reduced simulation
// constants. A reference model predicts every pulse and its cycle from the
// raw key press and release lengths.
module tb_morse_key_timer;
  import morse_pkg::*;

  typedef struct {
    int kind;
    int t;
  } ev_t;

  localparam int K_DOT  = 0;
  localparam int K_DASH = 1;
  localparam int K_BKSP = 2;
  localparam int K_CONF = 3;

  // Raw key edge to registered pulse: 2 sync flops, debounce period, output register
  localparam int LAT = 2 + SIM_DEBOUNCE_CYC + 1;

`ifdef MORSE_DASH_LED_EN
  localparam logic LED_EN = 1'b1;
`else
  localparam logic LED_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  logic key;
  logic dot;
  logic dash;
  logic backspace;
  logic confirm;
  logic busy;
  logic dash_ready;

  int   cyc;
  int   checks;
  int   errors;
  int   multi;
  logic busy_seen;
  logic dr_seen;
  logic deb_seen;
  ev_t  got[$];
  ev_t  exp_q[$];

  morse_key_timer #(
    .DEBOUNCE_CYC(SIM_DEBOUNCE_CYC),
    .DASH_CYC(SIM_DASH_CYC),
    .BKSP_CYC(SIM_BKSP_CYC),
    .GAP_CYC(SIM_GAP_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key(key),
    .dot(dot),
    .dash(dash),
    .backspace(backspace),
    .confirm(confirm),
    .busy(busy),
    .dash_ready(dash_ready)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index used to timestamp drives and observed pulses
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk_ev(input int kind, input int t);
    ev_t e;
    e.kind = kind;
    e.t    = t;
    return e;
  endfunction

  // Record every pulse away from the active edge and note illegal overlaps
  always @(negedge clk) begin
    if (!rst) begin
      if (dot)       got.push_back(mk_ev(K_DOT, cyc));
      if (dash)      got.push_back(mk_ev(K_DASH, cyc));
      if (backspace) got.push_back(mk_ev(K_BKSP, cyc));
      if (confirm)   got.push_back(mk_ev(K_CONF, cyc));
      if ((int'(dot) + int'(dash) + int'(backspace) + int'(confirm)) > 1) multi++;
      if (busy) busy_seen = 1'b1;
      if (dash_ready) dr_seen = 1'b1;
      if (dut.u_debounce.deb) deb_seen = 1'b1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one clean press of len cycles followed by gap low cycles and predict its pulses
  task automatic press_release(input int len, input int gap);
    int c;
    int kind;
    key = 1'b1;
    step(len);
    c = cyc;
    key = 1'b0;
    if (len < SIM_DASH_CYC) kind = K_DOT;
    else if (len < SIM_BKSP_CYC) kind = K_DASH;
    else kind = K_BKSP;
    exp_q.push_back(mk_ev(kind, c + LAT));
    if (kind != K_BKSP && gap > SIM_GAP_CYC)
      exp_q.push_back(mk_ev(K_CONF, c + LAT + SIM_GAP_CYC));
    step(gap);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key = 1'b0;
    step(4);
    checks++;
    if ({dot, dash, backspace, confirm, busy, dash_ready} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %b want 000000", {dot, dash, backspace, confirm, busy, dash_ready});
    end
    rst = 1'b0;
    step(3);
    checks++;
    if ({dot, dash, backspace, confirm, busy, dash_ready} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL idle_outputs got %b want 000000", {dot, dash, backspace, confirm, busy, dash_ready});
    end
  endtask

  task automatic test_dot_confirm();
    int c;
    got.delete();
    exp_q.delete();
    key = 1'b1;
    step(6);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_before_press got %b want 0", busy);
    end
    step(2);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_in_press got %b want 1", busy);
    end
    step(2);
    c = cyc;
    key = 1'b0;
    exp_q.push_back(mk_ev(K_DOT, c + LAT));
    exp_q.push_back(mk_ev(K_CONF, c + LAT + SIM_GAP_CYC));
    step(30);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_in_gap got %b want 1", busy);
    end
    step(LAT + SIM_GAP_CYC - 31);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_before_confirm got %b want 1", busy);
    end
    step(1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_at_confirm got %b want 0", busy);
    end
    step(10);
    checks++;
    if (got.size() !== exp_q.size()) begin
      errors++;
      $display("[TB] FAIL dot_confirm_count got %0d want %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i].kind !== exp_q[i].kind || got[i].t !== exp_q[i].t) begin
        errors++;
        $display("[TB] FAIL dot_confirm_ev%0d got kind %0d at %0d want kind %0d at %0d",
                 i, got[i].kind, got[i].t, exp_q[i].kind, exp_q[i].t);
      end
    end
  endtask

  task automatic test_dash_continuation();
    int c;
    got.delete();
    exp_q.delete();
    key = 1'b1;
    step(30);
    c = cyc;
    key = 1'b0;
    exp_q.push_back(mk_ev(K_DASH, c + LAT));
    step(LAT - 1);
    checks++;
    if (dash_ready !== LED_EN) begin
      errors++;
      $display("[TB] FAIL dash_ready_before_release got %b want %b", dash_ready, LED_EN);
    end
    step(1);
    checks++;
    if (dash_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL dash_ready_after_release got %b want 0", dash_ready);
    end
    step(25 - LAT);
    press_release(12, 60);
    step(10);
    checks++;
    if (got.size() !== exp_q.size()) begin
      errors++;
      $display("[TB] FAIL dash_cont_count got %0d want %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i].kind !== exp_q[i].kind || got[i].t !== exp_q[i].t) begin
        errors++;
        $display("[TB] FAIL dash_cont_ev%0d got kind %0d at %0d want kind %0d at %0d",
                 i, got[i].kind, got[i].t, exp_q[i].kind, exp_q[i].t);
      end
    end
  endtask

  task automatic test_backspace();
    got.delete();
    exp_q.delete();
    press_release(70, 110);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_after_backspace got %b want 0", busy);
    end
    checks++;
    if (got.size() !== exp_q.size()) begin
      errors++;
      $display("[TB] FAIL backspace_count got %0d want %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i].kind !== exp_q[i].kind || got[i].t !== exp_q[i].t) begin
        errors++;
        $display("[TB] FAIL backspace_ev%0d got kind %0d at %0d want kind %0d at %0d",
                 i, got[i].kind, got[i].t, exp_q[i].kind, exp_q[i].t);
      end
    end
  endtask

  task automatic test_bounce();
    got.delete();
    busy_seen = 1'b0;
    deb_seen  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      key = (i % 2 == 0);
      step(2);
    end
    key = 1'b0;
    step(40);
    checks++;
    if (deb_seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bounce_deb got %b want 0", deb_seen);
    end
    checks++;
    if (busy_seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bounce_busy got %b want 0", busy_seen);
    end
    checks++;
    if (got.size() !== 0) begin
      errors++;
      $display("[TB] FAIL bounce_pulses got %0d want 0", got.size());
    end
  endtask

  task automatic test_gap_race();
    got.delete();
    exp_q.delete();
    press_release(12, SIM_GAP_CYC);
    press_release(30, SIM_GAP_CYC + 1);
    press_release(12, 60);
    step(10);
    checks++;
    if (got.size() !== exp_q.size()) begin
      errors++;
      $display("[TB] FAIL gap_race_count got %0d want %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i].kind !== exp_q[i].kind || got[i].t !== exp_q[i].t) begin
        errors++;
        $display("[TB] FAIL gap_race_ev%0d got kind %0d at %0d want kind %0d at %0d",
                 i, got[i].kind, got[i].t, exp_q[i].kind, exp_q[i].t);
      end
    end
  endtask

  task automatic test_reset_mid_press();
    got.delete();
    key = 1'b1;
    step(LAT + SIM_DASH_CYC - 1);
    checks++;
    if (dash_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL dash_ready_cnt19 got %b want 0", dash_ready);
    end
    step(1);
    checks++;
    if (dash_ready !== LED_EN) begin
      errors++;
      $display("[TB] FAIL dash_ready_cnt20 got %b want %b", dash_ready, LED_EN);
    end
    step(5);
    rst = 1'b1;
    step(1);
    checks++;
    if ({dot, dash, backspace, confirm, busy, dash_ready} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_press_outputs got %b want 000000",
               {dot, dash, backspace, confirm, busy, dash_ready});
    end
    got.delete();
    busy_seen = 1'b0;
    dr_seen   = 1'b0;
    rst = 1'b0;
    key = 1'b0;
    step(80);
    checks++;
    if (got.size() !== 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_press_pulses got %0d want 0", got.size());
    end
    checks++;
    if (busy_seen !== 1'b0 || dr_seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_press_busy got busy %b led %b want 0 0", busy_seen, dr_seen);
    end
  endtask

  task automatic test_random();
    int nsym;
    int len;
    int gap;
    got.delete();
    exp_q.delete();
    for (int l = 0; l < 8; l++) begin
      nsym = $urandom_range(1, 4);
      for (int s = 0; s < nsym; s++) begin
        len = $urandom_range(8, 80);
        for (int r = 0; r < 50 && ((len >= 19 && len <= 22) || (len >= 59 && len <= 62)); r++)
          len = $urandom_range(8, 80);
        if (len >= 19 && len <= 22) len = 12;
        if (len >= 59 && len <= 62) len = 70;
        if (s == nsym - 1 || $urandom_range(0, 3) == 0) gap = $urandom_range(45, 60);
        else gap = $urandom_range(8, 30);
        press_release(len, gap);
      end
    end
    step(10);
    checks++;
    if (got.size() !== exp_q.size()) begin
      errors++;
      $display("[TB] FAIL random_count got %0d want %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i].kind !== exp_q[i].kind || got[i].t !== exp_q[i].t) begin
        errors++;
        $display("[TB] FAIL random_ev%0d got kind %0d at %0d want kind %0d at %0d",
                 i, got[i].kind, got[i].t, exp_q[i].kind, exp_q[i].t);
      end
    end
    checks++;
    if (multi !== 0) begin
      errors++;
      $display("[TB] FAIL pulse_exclusive got %0d overlapping cycles want 0", multi);
    end
  endtask

  // Run every scenario in order and report
  initial begin
    checks    = 0;
    errors    = 0;
    multi     = 0;
    busy_seen = 1'b0;
    dr_seen   = 1'b0;
    deb_seen  = 1'b0;
    rst       = 1'b1;
    key       = 1'b0;
    test_reset();
    test_dot_confirm();
    test_dash_continuation();
    test_backspace();
    test_bounce();
    test_gap_race();
    test_reset_mid_press();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
